// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and defaults for the DataMemory port arbiter
// Contents: master id enum (M0 = LSU, M1 = debug/DMA), response record,
// default data width, memory depth and starvation limit.
package dmem_arb_pkg;

    localparam int unsigned DEF_WIDTH        = 32;
    localparam int unsigned DEF_DEPTH        = 512;
    localparam int unsigned DEF_STARVE_LIMIT = 4;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } master_id_t;

    typedef struct packed {
        logic                 valid;
        logic                 err;
        logic [DEF_WIDTH-1:0] data;
    } resp_t;

endpackage

// File: rtl/dmem_arb_pick.sv
// rtl/dmem_arb_pick.sv - combinational grant select between the two masters
// Ports:
//   req0, req1  in   request from M0 / M1
//   last_gnt    in   master granted most recently (round-robin tie break)
//   starved     in   M1 has lost StarveLimit cycles in a row (fixed priority)
//   rr_mode     in   1 = round-robin on conflict, 0 = fixed priority M0
//   gnt0, gnt1  out  one-hot-or-zero grant
module dmem_arb_pick
    import dmem_arb_pkg::*;
(
    input  logic       req0,
    input  logic       req1,
    input  master_id_t last_gnt,
    input  logic       starved,
    input  logic       rr_mode,
    output logic       gnt0,
    output logic       gnt1
);

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (req0 && req1) begin
            if (rr_mode) begin
                // Conflict goes to whoever did not win last time.
                if (last_gnt == M0) begin
                    gnt1 = 1'b1;
                end else begin
                    gnt0 = 1'b1;
                end
            end else if (starved) begin
                gnt1 = 1'b1;
            end else begin
                gnt0 = 1'b1;
            end
        end else begin
            gnt0 = req0;
            gnt1 = req1;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - shares the single-port DataMemory between LSU (M0) and debug/DMA (M1)
// Build option: DMEM_ARB_ROUND_ROBIN_EN selects round-robin conflict resolution;
// otherwise M0 has fixed priority and M1 is forced through after StarveLimit losses.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   mN_req/we/addr/wdata       request from master N (byte address), held until mN_gnt
//   mN_gnt                     combinational accept
//   mN_rvalid/rdata/err        registered one-cycle response for reads and illegal accesses
//   mem_we/re/addr/wdata       to DataMemory (addr is a word index)
//   mem_rdata                  from DataMemory, valid the cycle after mem_re
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned Width       = DEF_WIDTH,
    parameter int unsigned Depth       = DEF_DEPTH,
    parameter int unsigned StarveLimit = DEF_STARVE_LIMIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             m0_req,
    input  logic             m0_we,
    input  logic [Width-1:0] m0_addr,
    input  logic [Width-1:0] m0_wdata,
    output logic             m0_gnt,
    output logic             m0_rvalid,
    output logic [Width-1:0] m0_rdata,
    output logic             m0_err,
    input  logic             m1_req,
    input  logic             m1_we,
    input  logic [Width-1:0] m1_addr,
    input  logic [Width-1:0] m1_wdata,
    output logic             m1_gnt,
    output logic             m1_rvalid,
    output logic [Width-1:0] m1_rdata,
    output logic             m1_err,
    output logic             mem_we,
    output logic             mem_re,
    output logic [Width-1:0] mem_addr,
    output logic [Width-1:0] mem_wdata,
    input  logic [Width-1:0] mem_rdata
);

    localparam logic [Width-1:0] DepthW = Width'(Depth);

    master_id_t       last_gnt;
    master_id_t       rd_owner;
    master_id_t       sel;
    logic             rsp_valid;
    logic             rsp_err;
    logic             starved;
    logic             rr_mode;
    logic             any_gnt;
    logic             acc_we;
    logic [Width-1:0] acc_addr;
    logic [Width-1:0] acc_wdata;
    logic [Width-1:0] word_idx;
    logic             legal;
    resp_t            rsp;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    assign rr_mode = 1'b1;
    assign starved = 1'b0;
`else
    localparam int unsigned SW = $clog2(StarveLimit + 1);

    logic [SW-1:0] starve_cnt;

    assign rr_mode = 1'b0;
    assign starved = (starve_cnt == SW'(StarveLimit));

    // Counts consecutive cycles M1 asks and loses; any win or dropped
    // request restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!m1_req || m1_gnt) begin
            starve_cnt <= '0;
        end else if (!starved) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`endif

    dmem_arb_pick u_pick (
        .req0     (m0_req),
        .req1     (m1_req),
        .last_gnt (last_gnt),
        .starved  (starved),
        .rr_mode  (rr_mode),
        .gnt0     (m0_gnt),
        .gnt1     (m1_gnt)
    );

    assign any_gnt   = m0_gnt | m1_gnt;
    assign sel       = m1_gnt ? M1 : M0;
    assign acc_we    = (sel == M1) ? m1_we    : m0_we;
    assign acc_addr  = (sel == M1) ? m1_addr  : m0_addr;
    assign acc_wdata = (sel == M1) ? m1_wdata : m0_wdata;
    assign word_idx  = {2'b00, acc_addr[Width-1:2]};
    assign legal     = (acc_addr[1:0] == 2'b00) && (word_idx < DepthW);

    // Illegal accesses are accepted but never reach the memory; rst_n gating
    // keeps the memory quiet for the whole reset window.
    assign mem_we    = rst_n && any_gnt && legal && acc_we;
    assign mem_re    = rst_n && any_gnt && legal && !acc_we;
    assign mem_addr  = word_idx;
    assign mem_wdata = acc_wdata;

    // Response pipe: a read, or any illegal access, answers next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rd_owner  <= M0;
            last_gnt  <= M1;
        end else begin
            rsp_valid <= any_gnt && (!acc_we || !legal);
            rsp_err   <= any_gnt && !legal;
            if (any_gnt) begin
                rd_owner <= sel;
                last_gnt <= sel;
            end
        end
    end

    always_comb begin
        rsp.valid = rsp_valid;
        rsp.err   = rsp_err;
        rsp.data  = rsp_err ? '0 : mem_rdata;
    end

    assign m0_rvalid = rsp.valid && (rd_owner == M0);
    assign m1_rvalid = rsp.valid && (rd_owner == M1);
    assign m0_err    = m0_rvalid && rsp.err;
    assign m1_err    = m1_rvalid && rsp.err;
    assign m0_rdata  = m0_rvalid ? rsp.data : '0;
    assign m1_rdata  = m1_rvalid ? rsp.data : '0;

endmodule
